// File: rtl/aes_pkg.sv
// aes_pkg: types, constants and byte-level AES transforms used by aes_core_param.
//   aes_state_e : control states (IDLE, FETCH)
//   nr_of()     : number of rounds for a given key length
//   sub_bytes / shift_rows / mix_columns / add_round_key : AES round primitives.
// The state layout uses FIPS-197 byte order: byte 0 is bits [127:120], and
// byte index = row + 4*column.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int RK_IDX_W    = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } aes_state_e;

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] st);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] st);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] st, input logic [127:0] rk);
    return st ^ rk;
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// aes_round_unit: combinational AES round step.
//   state      in  128  current cipher state
//   round_key  in  128  round key for this step
//   is_first   in  1    initial AddRoundKey only
//   is_final   in  1    last round (no MixColumns)
//   next_state out 128  state after the step
// A single SubBytes/ShiftRows path feeds both normal and final rounds.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   is_first,
  input  logic                   is_final,
  output logic [AES_BLOCK_W-1:0] next_state
);

  logic [AES_BLOCK_W-1:0] sb_s;
  logic [AES_BLOCK_W-1:0] sr_s;
  logic [AES_BLOCK_W-1:0] mc_s;

  // Round datapath and step-type selection.
  always_comb begin
    sb_s = sub_bytes(state);
    sr_s = shift_rows(sb_s);
    mc_s = mix_columns(sr_s);
    if (is_first) begin
      next_state = add_round_key(state, round_key);
    end else if (is_final) begin
      next_state = add_round_key(sr_s, round_key);
    end else begin
      next_state = add_round_key(mc_s, round_key);
    end
  end

endmodule

// File: rtl/aes_core_param.sv
// aes_core_param: iterative AES encryption core (AES-128/192/256).
//   One round step every RK_LAT+1 cycles; round keys come from an external
//   key-expansion block addressed by rk_idx.
// Parameters: KEY_BITS (128/192/256), RK_LAT (0..3 cycles round-key latency).
// Ports:
//   clk, reset_n (synchronous, active low)
//   in_valid/in_ready/data_in   : plaintext handshake
//   key_ready                   : all round keys available (sampled at accept)
//   rk_idx/rk_in                : round-key request index and returned key
//   out_valid/out_ready/data_out: ciphertext handshake, held until consumed
// Optional build macro AES_CORE_CBC_EN adds iv_in/iv_load and CBC chaining.
module aes_core_param
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int RK_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] data_in,
  input  logic                   key_ready,
  output logic [RK_IDX_W-1:0]    rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] data_out
`ifdef AES_CORE_CBC_EN
  ,
  input  logic [AES_BLOCK_W-1:0] iv_in,
  input  logic                   iv_load
`endif
);

  localparam int                  NR        = nr_of(KEY_BITS);
  localparam logic [RK_IDX_W-1:0] NR_IDX    = RK_IDX_W'(NR);
  localparam logic [1:0]          WAIT_INIT = 2'(RK_LAT);

  aes_state_e             state_r, state_nx_s;
  logic [AES_BLOCK_W-1:0] blk_r, blk_nx_s;
  logic [RK_IDX_W-1:0]    step_r, step_nx_s;
  logic [RK_IDX_W-1:0]    rk_idx_r, rk_idx_nx_s;
  logic [1:0]             wait_cnt_r, wait_cnt_nx_s;
  logic                   out_valid_r, out_valid_nx_s;
  logic [AES_BLOCK_W-1:0] data_out_r, data_out_nx_s;
  logic [AES_BLOCK_W-1:0] round_out_s;
  logic [AES_BLOCK_W-1:0] chain_s;
  logic                   in_ready_s;

`ifdef AES_CORE_CBC_EN
  logic [AES_BLOCK_W-1:0] chain_r, chain_nx_s;
  assign chain_s = chain_r;
`else
  assign chain_s = 128'h0;
`endif

  aes_round_unit u_round (
    .state      (blk_r),
    .round_key  (rk_in),
    .is_first   (step_r == 4'd0),
    .is_final   (step_r == NR_IDX),
    .next_state (round_out_s)
  );

  assign in_ready_s = (state_r == IDLE) & key_ready & (~out_valid_r | out_ready);
  assign in_ready   = in_ready_s;
  assign rk_idx     = rk_idx_r;
  assign out_valid  = out_valid_r;
  assign data_out   = data_out_r;

  // Next-state, round sequencing and output-handshake logic.
  always_comb begin
    state_nx_s     = state_r;
    blk_nx_s       = blk_r;
    step_nx_s      = step_r;
    rk_idx_nx_s    = rk_idx_r;
    wait_cnt_nx_s  = wait_cnt_r;
    data_out_nx_s  = data_out_r;
`ifdef AES_CORE_CBC_EN
    chain_nx_s     = chain_r;
`endif
    // Consumption first; a completing block below overrides it.
    if (out_valid_r && out_ready) begin
      out_valid_nx_s = 1'b0;
    end else begin
      out_valid_nx_s = out_valid_r;
    end

    case (state_r)
      IDLE: begin
`ifdef AES_CORE_CBC_EN
        if (iv_load) begin
          chain_nx_s = iv_in;
        end else begin
          chain_nx_s = chain_r;
        end
`endif
        if (in_valid && in_ready_s) begin
          blk_nx_s      = data_in ^ chain_s;
          rk_idx_nx_s   = 4'd0;
          step_nx_s     = 4'd0;
          wait_cnt_nx_s = WAIT_INIT;
          state_nx_s    = FETCH;
        end else begin
          state_nx_s    = IDLE;
        end
      end
      FETCH: begin
        if (wait_cnt_r != 2'd0) begin
          wait_cnt_nx_s = wait_cnt_r - 2'd1;
        end else if (step_r == NR_IDX) begin
          data_out_nx_s  = round_out_s;
          out_valid_nx_s = 1'b1;
          state_nx_s     = IDLE;
`ifdef AES_CORE_CBC_EN
          chain_nx_s     = round_out_s;
`endif
        end else begin
          blk_nx_s      = round_out_s;
          step_nx_s     = step_r + 4'd1;
          rk_idx_nx_s   = step_r + 4'd1;
          wait_cnt_nx_s = WAIT_INIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Register bank; reset_n is sampled on the clock edge and aborts any block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      blk_r       <= 128'h0;
      step_r      <= 4'd0;
      rk_idx_r    <= 4'd0;
      wait_cnt_r  <= 2'd0;
      out_valid_r <= 1'b0;
      data_out_r  <= 128'h0;
`ifdef AES_CORE_CBC_EN
      chain_r     <= 128'h0;
`endif
    end else begin
      state_r     <= state_nx_s;
      blk_r       <= blk_nx_s;
      step_r      <= step_nx_s;
      rk_idx_r    <= rk_idx_nx_s;
      wait_cnt_r  <= wait_cnt_nx_s;
      out_valid_r <= out_valid_nx_s;
      data_out_r  <= data_out_nx_s;
`ifdef AES_CORE_CBC_EN
      chain_r     <= chain_nx_s;
`endif
    end
  end

endmodule

// File: tb/tb_aes_core_param.sv
// tb_aes_core_param: directed self-checking bench for aes_core_param.
// Three instances: AES-128/RK_LAT=0, AES-192/RK_LAT=1, AES-256/RK_LAT=2.
// Each has a key-source model that returns the expanded round key for rk_idx
// after RK_LAT cycles. With AES_CORE_CBC_EN defined, a CBC test runs too.
module tb_aes_core_param;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] data_in   [3];
  logic         key_ready [3];
  logic [3:0]   rk_idx    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] data_out  [3];
  logic [127:0] rk_in_a, rk_in_b, rk_in_c, rk_p_c;
  logic [127:0] rk_tab [3][16];
`ifdef AES_CORE_CBC_EN
  logic [127:0] iv_in   [3];
  logic         iv_load [3];
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  always #5 clk = ~clk;

  aes_core_param #(.KEY_BITS(128), .RK_LAT(0)) u_aes128 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .key_ready(key_ready[0]), .rk_idx(rk_idx[0]), .rk_in(rk_in_a),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0])
`ifdef AES_CORE_CBC_EN
    , .iv_in(iv_in[0]), .iv_load(iv_load[0])
`endif
  );

  aes_core_param #(.KEY_BITS(192), .RK_LAT(1)) u_aes192 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .key_ready(key_ready[1]), .rk_idx(rk_idx[1]), .rk_in(rk_in_b),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1])
`ifdef AES_CORE_CBC_EN
    , .iv_in(iv_in[1]), .iv_load(iv_load[1])
`endif
  );

  aes_core_param #(.KEY_BITS(256), .RK_LAT(2)) u_aes256 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in[2]), .key_ready(key_ready[2]), .rk_idx(rk_idx[2]), .rk_in(rk_in_c),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .data_out(data_out[2])
`ifdef AES_CORE_CBC_EN
    , .iv_in(iv_in[2]), .iv_load(iv_load[2])
`endif
  );

  // Key sources with 0, 1 and 2 cycles of latency.
  assign rk_in_a = rk_tab[0][rk_idx[0]];
  always @(posedge clk) rk_in_b <= rk_tab[1][rk_idx[1]];
  always @(posedge clk) begin
    rk_p_c  <= rk_tab[2][rk_idx[2]];
    rk_in_c <= rk_p_c;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box via brute-force inverse search plus affine transform.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv, y;
    inv = 8'h00;
    for (int k = 1; k < 256; k++) begin
      y = 8'(k);
      if (tb_gmul(x, y) == 8'h01) inv = y;
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion; key is left-aligned in 256 bits, nk = 4/6/8.
  task automatic expand(input int inst, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = t ^ w[i-nk];
    end
    for (int r = 0; r <= nr; r++) rk_tab[inst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called #1 after the accepting edge; counts edges until out_valid, and
  // counts rk_idx samples that differ from min(n/unit, nr).
  task automatic wait_out(input int sel, input int unit, input int nr,
                          output int n, output int rk_bad);
    int exp_idx;
    n = 0;
    rk_bad = (int'(rk_idx[sel]) != 0) ? 1 : 0;
    while (!out_valid[sel] && n < 100) begin
      @(posedge clk); #1;
      n++;
      exp_idx = n / unit;
      if (exp_idx > nr) exp_idx = nr;
      if (int'(rk_idx[sel]) != exp_idx) rk_bad++;
    end
  endtask

  task automatic encrypt(input int sel, input logic [127:0] pt, input logic [127:0] ct,
                         input int unit, input int nr, input string tag);
    int n, rk_bad;
    check_eq({tag, "_in_ready"}, 128'(in_ready[sel]), 128'd1);
    data_in[sel]  = pt;
    in_valid[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    wait_out(sel, unit, nr, n, rk_bad);
    check_eq({tag, "_latency"}, 128'(n), 128'((nr + 1) * unit));
    check_eq({tag, "_data"}, data_out[sel], ct);
    check_eq({tag, "_rk_idx_seq_errs"}, 128'(rk_bad), 128'd0);
    out_ready[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready[sel] = 1'b0;
    check_eq({tag, "_out_valid_cleared"}, 128'(out_valid[sel]), 128'd0);
  endtask

  task automatic clear_chain(input int sel);
`ifdef AES_CORE_CBC_EN
    iv_in[sel]   = 128'h0;
    iv_load[sel] = 1'b1;
    @(posedge clk); #1;
    iv_load[sel] = 1'b0;
`else
    @(posedge clk); #1;
    if (sel < 0) $display("bad instance select");
`endif
  endtask

  initial begin
    int n, rk_bad, bad;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      data_in[i]   = 128'h0;
      key_ready[i] = 1'b0;
      out_ready[i] = 1'b0;
`ifdef AES_CORE_CBC_EN
      iv_in[i]   = 128'h0;
      iv_load[i] = 1'b0;
`endif
    end
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_out_valid", 128'(out_valid[i]), 128'd0);
      check_eq("rst_data_out", data_out[i], 128'h0);
      check_eq("rst_rk_idx", 128'(rk_idx[i]), 128'd0);
      check_eq("rst_in_ready", 128'(in_ready[i]), 128'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) key_ready[i] = 1'b1;
    #1;

    // Known-answer vectors.
    encrypt(0, PT, CT128, 1, 10, "aes128_lat0");
    encrypt(1, PT, CT192, 2, 12, "aes192_lat1");
    encrypt(2, PT, CT256, 3, 14, "aes256_lat2");

    // Backpressure, then output handshake and new accept on the same edge.
    clear_chain(0);
    data_in[0]  = PT;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_out(0, 1, 10, n, rk_bad);
    check_eq("bp_latency", 128'(n), 128'd11);
    in_valid[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (data_out[0] !== CT128 || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) bad++;
    end
    check_eq("bp_hold_errs", 128'(bad), 128'd0);
    out_ready[0] = 1'b1;
    #1;
    check_eq("bp_in_ready_on_release", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check_eq("b2b_out_valid_cleared", 128'(out_valid[0]), 128'd0);
    check_eq("b2b_accepted_busy", 128'(in_ready[0]), 128'd0);
    wait_out(0, 1, 10, n, rk_bad);
    check_eq("b2b_latency", 128'(n), 128'd11);
    check_eq("b2b_rk_idx_seq_errs", 128'(rk_bad), 128'd0);
`ifndef AES_CORE_CBC_EN
    check_eq("b2b_data", data_out[0], CT128);
`endif
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Reset during round 5 discards the block.
    data_in[0]  = PT;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_rst_rk_idx_before", 128'(rk_idx[0]), 128'd5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("mid_rst_rk_idx", 128'(rk_idx[0]), 128'd0);
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) bad++;
    end
    check_eq("mid_rst_no_out", 128'(bad), 128'd0);
    encrypt(0, PT, CT128, 1, 10, "after_rst");

`ifdef AES_CORE_CBC_EN
    // SP800-38A F.2.1 CBC-AES128 encryption, first two blocks.
    expand(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    iv_in[0]   = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load[0] = 1'b1;
    @(posedge clk); #1;
    iv_load[0] = 1'b0;
    encrypt(0, 128'h6bc1bee22e409f96e93d7e117393172a,
            128'h7649abac8119b246cee98e9b12e9197d, 1, 10, "cbc_blk1");
    encrypt(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
            128'h5086cb9b507219ee95db113a917678b2, 1, 10, "cbc_blk2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
